miss_fill_engine: RTL and testbench
===================================

# miss_fill_engine

Parametrised miss-handling engine for the instruction cache, successor to the fixed-width miss handler. It sits after the tag-compare stage: on a miss it chooses a victim way, issues one burst read for the whole block, writes each returned beat into the data array, and forwards the missed word as soon as it arrives. It then updates the tag and status arrays and releases the pipeline. Ways, sets, block length and word width are all parameters.

## Interface
- TAG_W, 8, tag bits per address
- SET_W, 4, set-index bits; the arrays have 2^SET_W rows
- OFF_W, 4, word-offset bits; a block holds 2^OFF_W words
- NUM_WAYS, 4, associativity (≥2)
- DATA_W, 20, instruction word width
- clk  in  1  clock; everything is on its rising edge
- arst_n  in  1  asynchronous active-low reset
- i_valid, i_cache_hit  in  1  lookup result; it is accepted only when o_ready=1
- i_tag, i_set, i_offset  in  TAG_W/SET_W/OFF_W  address fields of the lookup
- i_sa_valid_bits  in  NUM_WAYS  valid bits for the set being looked up
- o_ready  out  1  engine is idle and can accept a lookup
- o_miss_state  out  1  a miss is being handled
- o_mem_req_addr  out  TAG_W+SET_W+OFF_W  block address; the offset field is always zero
- o_mem_req_valid  out  1 / i_mem_req_ready  in  1  memory request handshake
- i_mem_data  in  DATA_W / i_mem_data_valid  in  1 / o_mem_data_ready  out  1  burst beat handshake; beats arrive in order, offset 0 first
- o_da_addr  out  SET_W+OFF_W ({set,offset}), o_da_data  out  DATA_W, o_da_mask  out  NUM_WAYS, o_da_valid  out  1, i_da_halt  in  1
- o_ta_addr  out  SET_W, o_ta_data  out  NUM_WAYS*TAG_W, o_ta_mask  out  NUM_WAYS, o_ta_valid  out  1, i_ta_halt  in  1
- o_sa_addr  out  SET_W, o_sa_data  out  NUM_WAYS, o_sa_mask  out  NUM_WAYS, o_sa_valid  out  1, i_sa_halt  in  1
- o_word  out  DATA_W / o_word_valid  out  1  missed word returned to the fetch stage
- o_done  out  1  one-cycle pulse when the miss completes

## Operation
- FSM states: IDLE, REQ, FILL, UPDATE, DONE.
- IDLE: o_ready=1. A lookup with i_valid=1 and i_cache_hit=1 is a hit and is ignored. A lookup with i_valid=1 and i_cache_hit=0:
  - captures tag, set, offset and the valid bits;
  - chooses the victim way;
  - moves to REQ.
- Victim choice: the lowest-index way whose valid bit is 0. If all ways are valid, the way pointed to by the round-robin pointer rr (width clog2(NUM_WAYS)). rr advances by 1 modulo NUM_WAYS only when rr was the way used. rr resets to 0.
- REQ: o_mem_req_valid=1, o_mem_req_addr={tag,set,0}. Move to FILL on the cycle i_mem_req_ready=1.
- FILL:
  - o_mem_data_ready=~i_da_halt.
  - A beat is accepted when i_mem_data_valid & o_mem_data_ready. On that cycle o_da_valid=1, o_da_addr={set,cnt}, o_da_data=i_mem_data, and o_da_mask=one-hot victim way.
  - The beat counter cnt (OFF_W bits) then increments.
  - When cnt equals the captured offset, the beat is also registered to o_word with o_word_valid=1 for exactly one cycle.
  - The beat with cnt=2^OFF_W−1 ends FILL; cnt wraps to 0.
- UPDATE:
  - o_ta_valid stays high until the first cycle with i_ta_halt=0. Then: o_ta_data has the captured tag replicated into every way slot, o_ta_mask=one-hot victim way, o_ta_addr=set.
  - o_sa_valid stays high until the first cycle with i_sa_halt=0. Then: o_sa_data=captured valid bits OR one-hot victim way, o_sa_mask=all ones.
  - The two writes complete independently; each has its own done flag.
  - Move to DONE once both are complete.
- DONE: o_done=1 for one cycle, then return to IDLE.
- o_miss_state=1 in every state except IDLE.
- Output-valid signals (o_mem_req_valid, o_da_valid, o_ta_valid, o_sa_valid) are 0 outside their own states.

## Timing
- Reset: all outputs are 0 except o_ready=1. State=IDLE, cnt=0, rr=0.
- Asserting arst_n low at any point, including mid-burst, aborts the miss immediately. No partial tag or status write is issued, and beats still in flight after reset are ignored.
- Capture cycle T: o_mem_req_valid=1 from T+1.
- Zero-wait memory (request accepted at T+1, one beat per cycle starting at T+2, no halts):
  - last beat at T+1+2^OFF_W;
  - tag and status writes at T+2+2^OFF_W;
  - o_done at T+3+2^OFF_W;
  - o_ready=1 again at T+4+2^OFF_W.
- o_word_valid is asserted on the cycle after the missed beat is accepted.
- i_da_halt=1 holds o_mem_data_ready=0 and o_da_valid=0. The beat is not lost; memory must hold it.
- A lookup presented while o_ready=0 is not captured; upstream must hold it.

## Test plan
- Reset, no memory activity -> o_ready=1 and every other output 0. Then a hit (i_valid=1, i_cache_hit=1) -> no state change.
- Miss tag=0xA5, set=3, offset=5, valid bits 4'b1011, zero-wait memory:
  - o_mem_req_addr=0xA530 at T+1;
  - 16 data writes to addresses 0x30–0x3F, each with mask 4'b0100;
  - o_word equal to beat 5, o_word_valid one cycle after that beat;
  - tag write at T+18 with mask 4'b0100, status write with data 4'b1111;
  - o_done at T+19.
- Four consecutive misses with valid bits 4'b1111 -> victim masks 0001, 0010, 0100, 1000, then wraps to 0001.
- i_da_halt=1 for 3 cycles during beat 7 -> beat 7 is written exactly once, no beat is lost or duplicated, and completion is 3 cycles later than the zero-wait case.
- During UPDATE, i_ta_halt=1 for 2 cycles and i_sa_halt=0 -> the status write completes first, the tag write is held for 2 cycles, and o_done fires 1 cycle after the tag write completes.
- arst_n pulsed low after beat 8 -> outputs return to reset values and no tag or status write occurs. A new miss afterwards completes normally, starting from cnt=0.

Source files
------------

// File: rtl/miss_fill_engine_if.sv
// miss_fill_engine_if: lookup, memory burst and array-write signals of the miss fill engine
interface miss_fill_engine_if #(
  parameter int TAG_W    = 8,
  parameter int SET_W    = 4,
  parameter int OFF_W    = 4,
  parameter int NUM_WAYS = 4,
  parameter int DATA_W   = 20
);
  logic                        i_valid, i_cache_hit;
  logic [TAG_W-1:0]            i_tag;
  logic [SET_W-1:0]            i_set;
  logic [OFF_W-1:0]            i_offset;
  logic [NUM_WAYS-1:0]         i_sa_valid_bits;
  logic                        o_ready, o_miss_state;
  logic [TAG_W+SET_W+OFF_W-1:0] o_mem_req_addr;
  logic                        o_mem_req_valid, i_mem_req_ready;
  logic [DATA_W-1:0]           i_mem_data;
  logic                        i_mem_data_valid, o_mem_data_ready;
  logic [SET_W+OFF_W-1:0]      o_da_addr;
  logic [DATA_W-1:0]           o_da_data;
  logic [NUM_WAYS-1:0]         o_da_mask;
  logic                        o_da_valid, i_da_halt;
  logic [SET_W-1:0]            o_ta_addr;
  logic [NUM_WAYS*TAG_W-1:0]   o_ta_data;
  logic [NUM_WAYS-1:0]         o_ta_mask;
  logic                        o_ta_valid, i_ta_halt;
  logic [SET_W-1:0]            o_sa_addr;
  logic [NUM_WAYS-1:0]         o_sa_data, o_sa_mask;
  logic                        o_sa_valid, i_sa_halt;
  logic [DATA_W-1:0]           o_word;
  logic                        o_word_valid, o_done;
  modport master (
    input  i_valid, i_cache_hit, i_tag, i_set, i_offset, i_sa_valid_bits,
           i_mem_req_ready, i_mem_data, i_mem_data_valid, i_da_halt, i_ta_halt, i_sa_halt,
    output o_ready, o_miss_state, o_mem_req_addr, o_mem_req_valid, o_mem_data_ready,
           o_da_addr, o_da_data, o_da_mask, o_da_valid,
           o_ta_addr, o_ta_data, o_ta_mask, o_ta_valid,
           o_sa_addr, o_sa_data, o_sa_mask, o_sa_valid,
           o_word, o_word_valid, o_done
  );
  modport slave (
    output i_valid, i_cache_hit, i_tag, i_set, i_offset, i_sa_valid_bits,
           i_mem_req_ready, i_mem_data, i_mem_data_valid, i_da_halt, i_ta_halt, i_sa_halt,
    input  o_ready, o_miss_state, o_mem_req_addr, o_mem_req_valid, o_mem_data_ready,
           o_da_addr, o_da_data, o_da_mask, o_da_valid,
           o_ta_addr, o_ta_data, o_ta_mask, o_ta_valid,
           o_sa_addr, o_sa_data, o_sa_mask, o_sa_valid,
           o_word, o_word_valid, o_done
  );
endinterface

// File: rtl/miss_fill_engine.sv
// miss_fill_engine: picks a victim way, burst-fills the block, forwards the missed word, then writes tag and status
module miss_fill_engine #(
  parameter int TAG_W    = 8,
  parameter int SET_W    = 4,
  parameter int OFF_W    = 4,
  parameter int NUM_WAYS = 4,
  parameter int DATA_W   = 20
) (
  input logic clk,
  input logic arst_n,
  miss_fill_engine_if.master bus
);
  localparam int VW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  typedef enum logic [2:0] {IDLE, REQ, FILL, UPDATE, DONE} state_t;
  state_t state, state_nx;
  logic [TAG_W-1:0]    tag_q;
  logic [SET_W-1:0]    set_q;
  logic [OFF_W-1:0]    off_q, cnt;
  logic [NUM_WAYS-1:0] vbits_q, way_oh;
  logic [VW-1:0]       rr, victim, way_q;
  logic [DATA_W-1:0]   word_q;
  logic                word_valid_q, ta_done, sa_done;
  logic                miss, beat, ta_valid, sa_valid, ta_fire, sa_fire;
  // lowest-index invalid way wins; round-robin only when the set is full
  always_comb begin
    victim = rr;
    for (int k = NUM_WAYS - 1; k >= 0; k--)
      if (!bus.i_sa_valid_bits[k]) victim = VW'(k);
  end
  always_comb begin
    miss     = (state == IDLE) & bus.i_valid & ~bus.i_cache_hit;
    beat     = (state == FILL) & bus.i_mem_data_valid & ~bus.i_da_halt;
    ta_valid = (state == UPDATE) & ~ta_done;
    sa_valid = (state == UPDATE) & ~sa_done;
    ta_fire  = ta_valid & ~bus.i_ta_halt;
    sa_fire  = sa_valid & ~bus.i_sa_halt;
    state_nx = state;
    case (state)
      IDLE:    state_nx = miss ? REQ : IDLE;
      REQ:     state_nx = bus.i_mem_req_ready ? FILL : REQ;
      FILL:    state_nx = (beat & (&cnt)) ? UPDATE : FILL;
      UPDATE:  state_nx = ((ta_done | ta_fire) & (sa_done | sa_fire)) ? DONE : UPDATE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      tag_q        <= '0;
      set_q        <= '0;
      off_q        <= '0;
      vbits_q      <= '0;
      way_q        <= '0;
      rr           <= '0;
      cnt          <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      ta_done      <= 1'b0;
      sa_done      <= 1'b0;
    end else begin
      if (miss) begin
        tag_q   <= bus.i_tag;
        set_q   <= bus.i_set;
        off_q   <= bus.i_offset;
        vbits_q <= bus.i_sa_valid_bits;
        way_q   <= victim;
        if (victim == rr) rr <= (rr == VW'(NUM_WAYS - 1)) ? '0 : rr + 1'b1;
      end
      if (beat) cnt <= cnt + 1'b1;
      word_valid_q <= beat & (cnt == off_q);
      if (beat & (cnt == off_q)) word_q <= bus.i_mem_data;
      ta_done <= (state == UPDATE) & (ta_done | ta_fire);
      sa_done <= (state == UPDATE) & (sa_done | sa_fire);
    end
  assign way_oh               = NUM_WAYS'(1) << way_q;
  assign bus.o_ready          = state == IDLE;
  assign bus.o_miss_state     = state != IDLE;
  assign bus.o_mem_req_valid  = state == REQ;
  assign bus.o_mem_req_addr   = (state == REQ) ? {tag_q, set_q, {OFF_W{1'b0}}} : '0;
  assign bus.o_mem_data_ready = (state == FILL) & ~bus.i_da_halt;
  assign bus.o_da_valid       = beat;
  assign bus.o_da_addr        = beat ? {set_q, cnt} : '0;
  assign bus.o_da_data        = beat ? bus.i_mem_data : '0;
  assign bus.o_da_mask        = beat ? way_oh : '0;
  assign bus.o_ta_valid       = ta_valid;
  assign bus.o_ta_addr        = ta_valid ? set_q : '0;
  assign bus.o_ta_data        = ta_valid ? {NUM_WAYS{tag_q}} : '0;
  assign bus.o_ta_mask        = ta_valid ? way_oh : '0;
  assign bus.o_sa_valid       = sa_valid;
  assign bus.o_sa_addr        = sa_valid ? set_q : '0;
  assign bus.o_sa_data        = sa_valid ? (vbits_q | way_oh) : '0;
  assign bus.o_sa_mask        = sa_valid ? '1 : '0;
  assign bus.o_word           = word_q;
  assign bus.o_word_valid     = word_valid_q;
  assign bus.o_done           = state == DONE;
endmodule

// File: tb/tb_miss_fill_engine.sv
// tb_miss_fill_engine: table of directed misses against a cycle-level memory and array model
module tb_miss_fill_engine;
  localparam int TAG_W = 8, SET_W = 4, OFF_W = 4, NUM_WAYS = 4, DATA_W = 20, BEATS = 16;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;
  miss_fill_engine_if #(.TAG_W(TAG_W), .SET_W(SET_W), .OFF_W(OFF_W), .NUM_WAYS(NUM_WAYS), .DATA_W(DATA_W)) bus ();
  miss_fill_engine #(.TAG_W(TAG_W), .SET_W(SET_W), .OFF_W(OFF_W), .NUM_WAYS(NUM_WAYS), .DATA_W(DATA_W)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus)
  );
  typedef struct {
    logic [7:0] tag;
    logic [3:0] set, off, vb, mask, sa;
    int halt_len, ta_halt, exp_ta, exp_sa, exp_done, abort_after;
  } vec_t;
  vec_t tbl[10];
  int pass_n = 0, total_n = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask
  function automatic logic [19:0] bd(input logic [7:0] t, input logic [3:0] s, input logic [3:0] b);
    return {4'hC, t, s, b};
  endfunction
  task automatic idle_inputs();
    bus.i_valid = 0; bus.i_cache_hit = 0; bus.i_tag = '0; bus.i_set = '0; bus.i_offset = '0;
    bus.i_sa_valid_bits = '0; bus.i_mem_req_ready = 0; bus.i_mem_data = '0; bus.i_mem_data_valid = 0;
    bus.i_da_halt = 0; bus.i_ta_halt = 0; bus.i_sa_halt = 0;
  endtask
  task automatic chk_quiet(input string nm);
    chk({nm, "_ready"}, bus.o_ready, 1);
    chk({nm, "_valids"}, {bus.o_miss_state, bus.o_mem_req_valid, bus.o_mem_data_ready, bus.o_da_valid,
                          bus.o_ta_valid, bus.o_sa_valid, bus.o_word_valid, bus.o_done}, 0);
  endtask
  task automatic run_miss(input vec_t v);
    int bi = 0, hl = v.halt_len, tl = v.ta_halt;
    int req_c = -1, boff = -1, word_c = -1, words = 0, ta_c = -1, sa_c = -1, ta_n = 0, sa_n = 0, done_c = -1;
    bit req_seen = 0;
    @(negedge clk);
    bus.i_valid = 1; bus.i_cache_hit = 0; bus.i_tag = v.tag; bus.i_set = v.set;
    bus.i_offset = v.off; bus.i_sa_valid_bits = v.vb;
    #1 chk("ready_before_miss", bus.o_ready, 1);
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      @(negedge clk);
      if (bi == v.abort_after) begin
        bus.i_da_halt = 0; bus.i_mem_data_valid = 1;
        arst_n = 0;
        #1 chk_quiet("abort");
        chk("abort_zero_outs", {bus.o_mem_req_addr, bus.o_da_addr, bus.o_ta_mask, bus.o_sa_mask}, 0);
        repeat (2) @(negedge clk);
        arst_n = 1;
        repeat (3) begin
          @(negedge clk);
          #1 chk_quiet("after_abort");
        end
        idle_inputs();
        return;
      end
      bus.i_valid = 0; bus.i_sa_valid_bits = '0; bus.i_mem_req_ready = 1;
      bus.i_mem_data_valid = req_seen && bi < BEATS;
      bus.i_mem_data = bd(v.tag, v.set, 4'(bi));
      bus.i_da_halt = (bi == 7) && hl > 0;
      bus.i_ta_halt = (bi == BEATS) && tl > 0;
      #1;
      if (bus.i_da_halt) begin
        hl--;
        chk("halt_blocks_beat", {bus.o_mem_data_ready, bus.o_da_valid}, 0);
      end
      if (bus.o_mem_req_valid && !req_seen) begin
        req_c = c; req_seen = 1;
        chk("req_addr", bus.o_mem_req_addr, {v.tag, v.set, 4'h0});
      end
      if (bus.o_da_valid) begin
        chk("da_addr", bus.o_da_addr, {v.set, 4'(bi)});
        chk("da_mask", bus.o_da_mask, v.mask);
        chk("da_data", bus.o_da_data, bd(v.tag, v.set, 4'(bi)));
        if (bi == int'(v.off)) boff = c;
        bi++;
      end
      if (bus.o_word_valid) begin
        words++; word_c = c;
        chk("word", bus.o_word, bd(v.tag, v.set, v.off));
      end
      if (bus.o_ta_valid) begin
        if (bus.i_ta_halt) tl--;
        else begin
          ta_n++; ta_c = c;
          chk("ta_addr", bus.o_ta_addr, v.set);
          chk("ta_data", bus.o_ta_data, {4{v.tag}});
          chk("ta_mask", bus.o_ta_mask, v.mask);
        end
      end
      if (bus.o_sa_valid) begin
        sa_n++; sa_c = c;
        chk("sa_addr", bus.o_sa_addr, v.set);
        chk("sa_data", bus.o_sa_data, v.sa);
        chk("sa_mask", bus.o_sa_mask, 4'hF);
      end
      if (bus.o_done) done_c = c;
    end
    chk("req_cycle", req_c, 1);
    chk("beat_count", bi, BEATS);
    chk("word_count", words, 1);
    chk("word_cycle", word_c, boff + 1);
    chk("ta_writes", ta_n, 1);
    chk("sa_writes", sa_n, 1);
    chk("ta_cycle", ta_c, v.exp_ta);
    chk("sa_cycle", sa_c, v.exp_sa);
    chk("done_cycle", done_c, v.exp_done);
    idle_inputs();
    @(negedge clk);
    #1 chk("ready_after_done", bus.o_ready, 1);
  endtask
  initial begin
    tbl[0] = '{8'hA5, 4'd3,  4'd5,  4'b1011, 4'b0100, 4'b1111, 0, 0, 18, 18, 19, -1};
    tbl[1] = '{8'h11, 4'd1,  4'd0,  4'b1111, 4'b0001, 4'b1111, 0, 0, 18, 18, 19, -1};
    tbl[2] = '{8'h22, 4'd2,  4'd15, 4'b1111, 4'b0010, 4'b1111, 0, 0, 18, 18, 19, -1};
    tbl[3] = '{8'h33, 4'd5,  4'd7,  4'b1111, 4'b0100, 4'b1111, 0, 0, 18, 18, 19, -1};
    tbl[4] = '{8'h44, 4'd9,  4'd1,  4'b1111, 4'b1000, 4'b1111, 0, 0, 18, 18, 19, -1};
    tbl[5] = '{8'h55, 4'd12, 4'd9,  4'b1111, 4'b0001, 4'b1111, 0, 0, 18, 18, 19, -1};
    tbl[6] = '{8'h3C, 4'd15, 4'd9,  4'b0000, 4'b0001, 4'b0001, 3, 0, 21, 21, 22, -1};
    tbl[7] = '{8'h12, 4'd0,  4'd2,  4'b0110, 4'b0001, 4'b0111, 0, 2, 20, 18, 21, -1};
    tbl[8] = '{8'h5A, 4'd6,  4'd3,  4'b1111, 4'b0010, 4'b1111, 0, 0, 18, 18, 19, 9};
    tbl[9] = '{8'h77, 4'd8,  4'd8,  4'b1111, 4'b0001, 4'b1111, 0, 0, 18, 18, 19, -1};
    idle_inputs();
    repeat (2) @(negedge clk);
    #1 chk_quiet("reset");
    chk("reset_zero_outs", {bus.o_mem_req_addr, bus.o_da_addr, bus.o_da_data, bus.o_da_mask, bus.o_ta_data,
                            bus.o_sa_data, bus.o_word}, 0);
    arst_n = 1;
    @(negedge clk);
    bus.i_valid = 1; bus.i_cache_hit = 1; bus.i_tag = 8'hA5; bus.i_set = 4'd3;
    repeat (3) begin
      @(negedge clk);
      #1 chk_quiet("hit_ignored");
    end
    idle_inputs();
    for (int i = 0; i < 10; i++) run_miss(tbl[i]);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
